csa_resolve: RTL and testbench
==============================

CSA_RESOLVE -- requirements
Module: csa_resolve

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 64: width of each redundant operand and of the result.
REQ-002 SHALL have parameter SEG_WIDTH, default 16: bits resolved per cycle; INPUT_WIDTH SHALL be an integer multiple of SEG_WIDTH.
REQ-003 SHALL have parameter NUM_SEGS = INPUT_WIDTH/SEG_WIDTH, derived locally, not overridable.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: IN0/IN1 carry a valid redundant pair.
REQ-007 SHALL have port in_ready, output, 1: block can accept a pair.
REQ-008 SHALL have ports IN0 and IN1, input, INPUT_WIDTH each: the sum/carry pair from the compressor tree.
REQ-009 SHALL have port out_valid, output, 1: SUM/cout hold a resolved result.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port SUM, output, INPUT_WIDTH: (IN0+IN1) mod 2^INPUT_WIDTH.
REQ-012 SHALL have port cout, output, 1: carry out of bit INPUT_WIDTH-1.

Function
REQ-013 SHALL implement an FSM with states IDLE, ADD, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: on in_valid&in_ready, SHALL register IN0/IN1, clear segment counter and carry, go to ADD.
REQ-016 ADD: each cycle SHALL add segment k of both operands plus carry, write the low SEG_WIDTH bits to SUM segment k, store the carry, increment k.
REQ-017 ADD: the edge processing segment NUM_SEGS-1 SHALL move to DONE; out_valid rises exactly NUM_SEGS edges after the accepting edge.
REQ-018 DONE: on out_ready SHALL return to IDLE; SUM and cout SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 in_valid outside IDLE SHALL be ignored with no state change; back-to-back accepts have minimum spacing NUM_SEGS+2 cycles.
REQ-020 Segment counter SHALL be ceil(log2(NUM_SEGS)) bits, min 1; NUM_SEGS=1 SHALL work (single ADD cycle).
REQ-021 Arithmetic SHALL be unsigned; the final carry beyond bit INPUT_WIDTH-1 goes only to cout, with no other overflow indication.
REQ-022 SUM segments not yet written during ADD SHALL hold their previous values; consumers SHALL rely on SUM only while out_valid=1.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, counter 0, carry 0, SUM 0, cout 0, out_valid 0, in_ready 1 (after first clock-independent settle).
REQ-024 Reset during ADD or DONE SHALL abandon the operation with no output handshake.

Configuration
REQ-025 Macro CSA_RESOLVE_COUT_EN defined: cout SHALL carry the final carry per REQ-012, registered with the last segment.
REQ-026 Macro CSA_RESOLVE_COUT_EN undefined: cout SHALL be tied to 0, and no carry-out flop beyond the inter-segment carry SHALL exist.

Verification
REQ-027 Defaults: IN0=64'hFFFF_FFFF_FFFF_FFFF, IN1=1 -> out_valid after 4 edges, SUM=0, cout=1 (0 without macro).
REQ-028 IN0=64'h0000_0000_0000_FFFF, IN1=64'h0000_0000_0000_0001 -> SUM=64'h0000_0000_0001_0000, cout=0 (carry across segment boundary).
REQ-029 Hold out_ready=0 for 10 cycles after out_valid -> SUM/cout/out_valid stable; in_ready stays 0; out_ready=1 -> in_ready=1 the next cycle.
REQ-030 Pulse rst_n low during the 2nd ADD cycle -> outputs immediately at reset values; a new pair after release resolves correctly.
REQ-031 Assert in_valid continuously with changing data during ADD -> only the first pair is resolved; SUM matches the first pair.
REQ-032 1000 random pairs with random out_ready and SEG_WIDTH in {8,16,64} -> every SUM/cout matches a reference model; transactions are neither lost nor duplicated.

Source files
------------

// File: rtl/csa_resolve.sv
// csa_resolve: resolves a carry-save (sum/carry) pair into a binary sum, SEG_WIDTH bits per clock.
// Define CSA_RESOLVE_COUT_EN to drive the final carry onto cout; otherwise cout is tied to 0.
module csa_resolve #(
   parameter int INPUT_WIDTH = 64,
   parameter int SEG_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_WIDTH-1:0] IN0,
   input  logic [INPUT_WIDTH-1:0] IN1,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INPUT_WIDTH-1:0] SUM,
   output logic                   cout
);

   localparam int NUM_SEGS = INPUT_WIDTH / SEG_WIDTH;
   localparam int CNT_W    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
   localparam logic [CNT_W-1:0]       LAST_SEG = CNT_W'(NUM_SEGS - 1);
   localparam logic [INPUT_WIDTH-1:0] SEG_MASK = INPUT_WIDTH'({SEG_WIDTH{1'b1}});

   if (INPUT_WIDTH % SEG_WIDTH != 0) begin : g_bad_width
      $error("INPUT_WIDTH must be an integer multiple of SEG_WIDTH");
   end

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

   state_e                 state_q, state_d;
   logic [INPUT_WIDTH-1:0] op0_q, op0_d, op1_q, op1_d;
   logic [INPUT_WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0]       seg_q, seg_d;
   logic                   carry_q, carry_d;

   logic [31:0]            seg_shift;
   logic [SEG_WIDTH-1:0]   seg0, seg1;
   logic [SEG_WIDTH:0]     seg_res;
   logic                   last_seg;

   // Segment k of each operand is brought down to bit 0 and added with the running carry.
   assign seg_shift = 32'(seg_q) * 32'(SEG_WIDTH);
   assign seg0      = SEG_WIDTH'(op0_q >> seg_shift);
   assign seg1      = SEG_WIDTH'(op1_q >> seg_shift);
   assign seg_res   = {1'b0, seg0} + {1'b0, seg1} + (SEG_WIDTH+1)'(carry_q);
   assign last_seg  = (seg_q == LAST_SEG);

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
      state_d = state_q;
      op0_d   = op0_q;
      op1_d   = op1_q;
      sum_d   = sum_q;
      seg_d   = seg_q;
      carry_d = carry_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               op0_d   = IN0;
               op1_d   = IN1;
               seg_d   = '0;
               carry_d = 1'b0;
               state_d = ADD;
            end
         end
         ADD: begin
            sum_d   = (sum_q & ~(SEG_MASK << seg_shift))
                    | (INPUT_WIDTH'(seg_res[SEG_WIDTH-1:0]) << seg_shift);
            carry_d = seg_res[SEG_WIDTH];
            seg_d   = seg_q + CNT_W'(1);
            if (last_seg) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sum_q   <= '0;
         seg_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         seg_q   <= seg_d;
         carry_q <= carry_d;
      end
   end

   // NOTE: operand registers are deliberately unreset; they are always loaded before being read.
   always_ff @(posedge clk) begin
      op0_q <= op0_d;
      op1_q <= op1_d;
   end

`ifdef CSA_RESOLVE_COUT_EN
   logic cout_q, cout_d;

   assign cout_d = (state_q == ADD && last_seg) ? seg_res[SEG_WIDTH] : cout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cout_q <= 1'b0;
      else        cout_q <= cout_d;
   end

   assign cout = cout_q;
`else
   assign cout = 1'b0;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign SUM       = sum_q;

endmodule

// File: tb/tb_csa_resolve.sv
// tb_csa_resolve: runs csa_resolve at SEG_WIDTH 8, 16 and 64 side by side, with directed and
// random carry-save pairs, comparing every cycle against a plain-arithmetic reference.
`timescale 1ns/1ps
module tb_csa_resolve;

   localparam int W  = 64;
   localparam int XW = W + 1;
`ifdef CSA_RESOLVE_COUT_EN
   localparam bit COUT_EN = 1'b1;
`else
   localparam bit COUT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: the full unsigned sum, carry in bit W.
   function automatic logic [XW-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [XW-1:0] ref_out(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [XW-1:0] r;
      r = ref_add(a, b);
      return {COUT_EN & r[W], r[W-1:0]};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int SW = (g == 0) ? 8 : (g == 1) ? 16 : 64;
      localparam int NS = W / SW;

      logic         rst_n, in_valid, in_ready, out_valid, out_ready, cout;
      logic         done, rand_mode, dir_rdy, rnd_rdy;
      logic [W-1:0] in0, in1, sum;
      logic [XW-1:0] exp_q[$];
      int           due_q[$];
      int           cyc   = 0;
      int           n_pop = 0;

      assign out_ready = rand_mode ? rnd_rdy : dir_rdy;

      csa_resolve #(.INPUT_WIDTH(W), .SEG_WIDTH(SW)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid),
         .in_ready (in_ready),
         .IN0      (in0),
         .IN1      (in1),
         .out_valid(out_valid),
         .out_ready(out_ready),
         .SUM      (sum),
         .cout     (cout)
      );

      always @(posedge clk) begin
         cyc++;
         #1 rnd_rdy = 1'($urandom_range(0, 1));
      end

      // Compare process: accepted pairs are queued with the cycle their result must appear.
      always @(negedge clk) begin
         if (!rst_n) begin
            exp_q.delete();
            due_q.delete();
            check($sformatf("sw%0d_rst_hs", SW), XW'({in_ready, out_valid, cout}), XW'(3'b100));
            check($sformatf("sw%0d_rst_sum", SW), XW'(sum), '0);
         end else if (exp_q.size() == 0) begin
            check($sformatf("sw%0d_idle_hs", SW), XW'({in_ready, out_valid}), XW'(2'b10));
         end else if (cyc < due_q[0]) begin
            check($sformatf("sw%0d_busy_hs", SW), XW'({in_ready, out_valid}), XW'(2'b00));
         end else begin
            check($sformatf("sw%0d_done_hs", SW), XW'({in_ready, out_valid}), XW'(2'b01));
            check($sformatf("sw%0d_result", SW), {cout, sum}, exp_q[0]);
            if (out_ready) begin
               void'(exp_q.pop_front());
               void'(due_q.pop_front());
               n_pop++;
            end
         end
         if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(ref_out(in0, in1));
            due_q.push_back(cyc + 1 + NS);
         end
      end

      task automatic tick();
         @(posedge clk);
         #1;
      endtask

      task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
         in0      = a;
         in1      = b;
         in_valid = 1'b1;
         for (int t = 0; t < 300 && !in_ready; t++) tick();
         check($sformatf("sw%0d_accept_wait", SW), XW'(in_ready), XW'(1));
         tick();
         in_valid = 1'b0;
      endtask

      task automatic wait_valid();
         for (int t = 0; t < 300 && !out_valid; t++) tick();
         check($sformatf("sw%0d_valid_wait", SW), XW'(out_valid), XW'(1));
      endtask

      initial begin
         logic [W-1:0] a, b;
         int           pop_base;
         rst_n = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0;
         dir_rdy = 1'b0; rand_mode = 1'b0; done = 1'b0;
         #1 rst_n = 1'b0;
         #1;
         check($sformatf("sw%0d_async_rst", SW), {cout, sum}, '0);
         check($sformatf("sw%0d_async_hs", SW), XW'({in_ready, out_valid}), XW'(2'b10));
         tick(); tick();
         rst_n = 1'b1;
         tick();

         // All ones plus one: every segment carries, result wraps to zero.
         send('1, 64'd1);
         repeat (NS - 1) tick();
         check($sformatf("sw%0d_lat_early", SW), XW'(out_valid), XW'(0));
         tick();
         check($sformatf("sw%0d_lat", SW), XW'(out_valid), XW'(1));
         check($sformatf("sw%0d_wrap", SW), {cout, sum}, {COUT_EN, {W{1'b0}}});
         repeat (10) tick();
         check($sformatf("sw%0d_hold_hs", SW), XW'({in_ready, out_valid}), XW'(2'b01));
         check($sformatf("sw%0d_hold_val", SW), {cout, sum}, {COUT_EN, {W{1'b0}}});
         dir_rdy = 1'b1;
         tick();
         dir_rdy = 1'b0;
         check($sformatf("sw%0d_release", SW), XW'({in_ready, out_valid}), XW'(2'b10));

         // Carry across the low 16-bit boundary.
         dir_rdy = 1'b1;
         send(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001);
         wait_valid();
         check($sformatf("sw%0d_seg_carry", SW), {cout, sum}, XW'(64'h0000_0000_0001_0000));
         tick();

         // in_valid held with changing data while busy: only the first pair counts.
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         send(a, b);
         in_valid = 1'b1;
         for (int t = 0; t < 300 && !out_valid; t++) begin
            in0 = {$urandom, $urandom};
            in1 = {$urandom, $urandom};
            tick();
         end
         in_valid = 1'b0;
         check($sformatf("sw%0d_first_only", SW), {cout, sum}, ref_out(a, b));
         tick();

         // Reset in the second ADD cycle abandons the operation.
         send({$urandom, $urandom}, {$urandom, $urandom});
         tick();
         rst_n = 1'b0;
         #1;
         check($sformatf("sw%0d_mid_rst", SW), XW'({in_ready, out_valid, cout}), XW'(3'b100));
         check($sformatf("sw%0d_mid_rst_sum", SW), XW'(sum), '0);
         tick(); tick();
         rst_n = 1'b1;
         tick();
         a = {$urandom, $urandom};
         b = '1;
         send(a, b);
         wait_valid();
         check($sformatf("sw%0d_post_rst", SW), {cout, sum}, ref_out(a, b));
         tick();

         // Random pairs, random gaps, random consumer back-pressure.
         rand_mode = 1'b1;
         pop_base  = n_pop;
         for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
               0:       b = ~a + 64'($urandom_range(0, 2));
               1:       a = '1;
               default: ;
            endcase
            repeat ($urandom_range(0, 2)) tick();
            send(a, b);
         end
         for (int t = 0; t < 300 && exp_q.size() != 0; t++) tick();
         check($sformatf("sw%0d_drain", SW), XW'(exp_q.size()), '0);
         check($sformatf("sw%0d_count", SW), XW'(n_pop - pop_base), XW'(1000));
         done = 1'b1;
      end
   end

   initial begin
      check("model_wrap", ref_add('1, 64'd1), 65'h1_0000_0000_0000_0000);
      check("model_seg", ref_add(64'hFFFF, 64'h1), 65'h0_0000_0000_0001_0000);
      check("model_max", ref_add('1, '1), 65'h1_FFFF_FFFF_FFFF_FFFE);
      for (int t = 0; t < 50000; t++) begin
         if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
         @(posedge clk);
      end
      check("all_done", XW'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done}), XW'(3'b111));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
